mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the IF stage (fetch) and the MEM stage (LW/SW) of the RV32I pipeline.
- Serialises the two requesters onto one memory port with a req/ready handshake. Data accesses have priority; a bounded starvation counter guarantees fetch progress.
- Generates per-stage stall signals that the pipeline control logic uses to freeze the PC and the pipeline registers.
- Supports fetch cancellation (flush) on taken branches, JAL and JALR.

Parameters:
- ADDR_W, 32, memory address width in bits.
- DATA_W, 32, memory data width in bits.
- STARVE_MAX, 3, number of consecutive data grants allowed while a fetch is waiting; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_valid or if_flush.
- if_addr  in  ADDR_W  fetch address (PC).
- if_flush  in  1  cancel the outstanding fetch (redirect).
- if_valid  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction.
- if_stall  out  1  if_req & ~if_valid.
- dm_req  in  1  data request (mem_read | mem_write); held stable until dm_valid.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address (ALU result).
- dm_wdata  in  DATA_W  store data.
- dm_valid  out  1  one-cycle pulse: data access complete.
- dm_rdata  out  DATA_W  load data; don't-care for stores.
- dm_stall  out  1  dm_req & ~dm_valid.
- mem_req  out  1  memory access active (registered).
- mem_we  out  1  write enable (registered).
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ready is high.
- mem_ready  in  1  memory completes the current access this cycle.

Behaviour:
- Reset: state=IDLE. mem_req, mem_we, mem_addr, mem_wdata, starve_cnt and discard all 0. if_valid and dm_valid are 0 on the cycle after rst.
- Mid-operation reset abandons any in-flight access. mem_req is low the cycle after rst; the memory tolerates an abandoned request.
- FSM states: IDLE, IF_BUSY, DM_BUSY.
- IDLE arbitration (evaluated each cycle):
  - dm_req only → DM_BUSY.
  - if_req & ~if_flush only → IF_BUSY.
  - Both → DM_BUSY, unless starve_cnt==STARVE_MAX, in which case IF_BUSY.
  - Neither → stay IDLE.
- On a grant: mem_req←1, and mem_addr/mem_we/mem_wdata are loaded from the winner. For fetches, mem_we←0 and mem_wdata←0.
- In a BUSY state, mem_req and the address/data registers hold until mem_ready.
- On mem_ready in a BUSY state:
  - Completing requester's valid = 1 (combinational on that cycle).
  - rdata = mem_rdata pass-through.
  - Next state = IDLE; mem_req←0, mem_we←0.
  - Every transaction therefore has one mandatory IDLE bubble, so a requester whose req is still high on its valid cycle is never re-granted twice.
- Minimum latency: req sampled in IDLE at cycle N → mem_req high at N+1 → valid at N+1 if mem_ready is already high. mem_ready latency is unbounded; the arbiter waits indefinitely.
- if_rdata and dm_rdata both track mem_rdata at all times. Only the valid pulses qualify them.
- Starvation counter:
  - On a DM grant with if_req high: starve_cnt increments, saturating at STARVE_MAX.
  - On an IF grant: starve_cnt←0.
  - On a DM grant with if_req low: starve_cnt unchanged.
- Flush:
  - if_flush in IF_BUSY (including on the mem_ready cycle) sets discard.
  - When the fetch completes with discard set (or flush on the same cycle), if_valid stays 0 and discard clears on leaving IF_BUSY.
  - if_flush in IDLE blocks an IF grant that cycle only.
  - if_flush in DM_BUSY has no effect.
- if_stall and dm_stall are combinational from req/valid. if_stall stays high during a discarded fetch.
- A dm_req arriving while IF_BUSY waits; it is granted after the IF transaction and the bubble.

Test Plan:
- Reset → all outputs 0. Then if_req=1, if_addr=0x100, memory with 2-cycle ready → mem_req high for 2 cycles with mem_addr=0x100, mem_we=0; if_valid pulses once with if_rdata=0x00500093; if_stall high until that cycle.
- Store: dm_req=1, dm_we=1, dm_addr=0x2000, dm_wdata=0xDEADBEEF → mem_we=1 with those values; dm_valid pulses once; next cycle mem_req=0, mem_we=0.
- Simultaneous if_req and dm_req held continuously, STARVE_MAX=2, 1-cycle memory → grant order DM, DM, IF, DM, DM, IF; one IDLE cycle between every transaction; starve_cnt returns to 0 after each IF grant.
- if_flush pulsed in the 2nd cycle of a 4-cycle fetch → the access completes on the memory side, if_valid never asserts, and the next fetch (new if_addr=0x200) is granted after the bubble.
- if_flush on the same cycle as mem_ready → if_valid stays 0. dm_req arriving while IF_BUSY → granted in the cycle after the IDLE bubble.
- rst asserted while DM_BUSY with mem_ready low → the next cycle has state IDLE, mem_req=0, starve_cnt=0 and no dm_valid; after rst deasserts, a held dm_req is re-granted and completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch (IF)
// and data access (MEM stage loads/stores).
//   - Data requests win arbitration. A fetch can wait through at most STARVE_MAX
//     consecutive data grants before it is granted.
//   - Every transaction is followed by a one-cycle IDLE bubble.
//   - Stall outputs let pipeline control freeze the PC and the pipeline registers.
//   - if_flush cancels an outstanding fetch on a redirect.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   if_req/if_addr/if_flush   fetch request, PC and redirect cancel
//   if_valid/if_rdata         fetch completion pulse and instruction word
//   if_stall                  fetch still pending
//   dm_req/dm_we/dm_addr/
//   dm_wdata                  data request, store enable, address and store data
//   dm_valid/dm_rdata         data completion pulse and load data
//   dm_stall                  data access still pending
//   mem_req/mem_we/mem_addr/
//   mem_wdata                 registered memory request
//   mem_rdata/mem_ready       memory read data and completion strobe
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  starve_q;
    logic [CNT_W-1:0]  starve_d;
    logic              discard_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic if_ok_c;
    logic starved_c;
    logic grant_dm_c;
    logic grant_if_c;

    // Arbitration in IDLE: data wins unless the waiting fetch has hit the limit.
    assign if_ok_c    = if_req & ~if_flush;
    assign starved_c  = (starve_q == CNT_MAX);
    assign grant_dm_c = (state_q == IDLE) & dm_req & ~(if_ok_c & starved_c);
    assign grant_if_c = (state_q == IDLE) & if_ok_c & ~grant_dm_c;

    // Starvation count: cleared by a fetch grant, bumped by a data grant that
    // passes over a pending fetch, saturating at the limit.
    always_comb begin
        starve_d = starve_q;
        if (grant_if_c) begin
            starve_d = '0;
        end else if (grant_dm_c && if_req && !starved_c) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Completion pulses; a discarded or concurrently flushed fetch is swallowed.
    assign if_valid  = (state_q == IF_BUSY) & mem_ready & ~discard_q & ~if_flush;
    assign dm_valid  = (state_q == DM_BUSY) & mem_ready;
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign if_stall  = if_req & ~if_valid;
    assign dm_stall  = dm_req & ~dm_valid;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Arbiter FSM and registered memory request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            discard_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    starve_q <= starve_d;
                    if (grant_dm_c) begin
                        state_q     <= DM_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we;
                        mem_addr_q  <= dm_addr;
                        mem_wdata_q <= dm_wdata;
                    end else if (grant_if_c) begin
                        state_q     <= IF_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                    end
                end
                IF_BUSY: begin
                    if (mem_ready) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        discard_q <= 1'b0;
                    end else if (if_flush) begin
                        discard_q <= 1'b1;
                    end
                end
                DM_BUSY: begin
                    if (mem_ready) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
